// File: rtl/register_file_pkg.sv
// Shared constants and address-legality helper for the parametrised register file.
package register_file_pkg;

    localparam int RF_WIDTH  = 32;
    localparam int RF_DEPTH  = 32;
    localparam int RF_ADDR_W = 5;

    localparam int unsigned RF_ZERO_ADDR = 0;

    // An address is legal to write or read from storage when it is inside the
    // array and is not the hardwired zero register.
    function automatic logic addr_legal(input int unsigned addr,
                                        input int unsigned depth,
                                        input bit          zero_reg);
        return (addr < depth) && !(zero_reg && (addr == RF_ZERO_ADDR));
    endfunction

endpackage

// File: rtl/register_file_read_port.sv
// One read port: zero/out-of-range/bypass selection followed by an
// enable-gated output register.
module register_file_read_port
    import register_file_pkg::*;
#(
    parameter int WIDTH    = RF_WIDTH,
    parameter int DEPTH    = RF_DEPTH,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic              wr_en0,
    input  logic [ADDR_W-1:0] aw0,
    input  logic [WIDTH-1:0]  dw0,
    input  logic              wr_en1,
    input  logic [ADDR_W-1:0] aw1,
    input  logic [WIDTH-1:0]  dw1,
    input  logic [WIDTH-1:0]  stored,
    output logic [WIDTH-1:0]  data
);

    logic [WIDTH-1:0] data_reg;
    logic [WIDTH-1:0] data_next;
    logic             legal;

    assign legal = addr_legal(32'(addr), DEPTH, ZERO_REG != 0);

    // Lane 1 is the younger instruction, so it is checked before lane 0.
    always_comb begin
        data_next = stored;
        if (!legal)
            data_next = '0;
        else if ((BYPASS != 0) && wr_en1 && (aw1 == addr))
            data_next = dw1;
        else if ((BYPASS != 0) && wr_en0 && (aw0 == addr))
            data_next = dw0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            data_reg <= '0;
        else if (rd_en)
            data_reg <= data_next;
    end

    assign data = data_reg;

endmodule

// File: rtl/register_file_param.sv
// Dual-write, dual-read register file with optional bypass and zero register.
// Storage is cleared on reset, so it is built from flops rather than block RAM.
module register_file_param
    import register_file_pkg::*;
#(
    parameter int WIDTH    = RF_WIDTH,
    parameter int DEPTH    = RF_DEPTH,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              WrEn0,
    input  logic [ADDR_W-1:0] Aw0,
    input  logic [WIDTH-1:0]  Dw0,
    input  logic              WrEn1,
    input  logic [ADDR_W-1:0] Aw1,
    input  logic [WIDTH-1:0]  Dw1,
    input  logic              RdEn,
    input  logic [ADDR_W-1:0] Aa,
    input  logic [ADDR_W-1:0] Ab,
    output logic [WIDTH-1:0]  Da,
    output logic [WIDTH-1:0]  Db
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic             wr_legal0;
    logic             wr_legal1;
    logic [WIDTH-1:0] stored_a;
    logic [WIDTH-1:0] stored_b;

    assign wr_legal0 = WrEn0 && addr_legal(32'(Aw0), DEPTH, ZERO_REG != 0);
    assign wr_legal1 = WrEn1 && addr_legal(32'(Aw1), DEPTH, ZERO_REG != 0);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_reg
            logic [WIDTH-1:0] q_reg;

            // Lane 1 takes priority when both lanes hit the same register.
            always_ff @(posedge clk or posedge reset) begin
                if (reset)
                    q_reg <= '0;
                else if (wr_legal1 && (Aw1 == ADDR_W'(gi)))
                    q_reg <= Dw1;
                else if (wr_legal0 && (Aw0 == ADDR_W'(gi)))
                    q_reg <= Dw0;
            end

            assign mem[gi] = q_reg;
        end
    endgenerate

    assign stored_a = (32'(Aa) < DEPTH) ? mem[Aa] : '0;
    assign stored_b = (32'(Ab) < DEPTH) ? mem[Ab] : '0;

    register_file_read_port #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W),
        .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
    ) u_port_a (
        .clk(clk), .reset(reset), .rd_en(RdEn), .addr(Aa),
        .wr_en0(WrEn0), .aw0(Aw0), .dw0(Dw0),
        .wr_en1(WrEn1), .aw1(Aw1), .dw1(Dw1),
        .stored(stored_a), .data(Da)
    );

    register_file_read_port #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W),
        .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
    ) u_port_b (
        .clk(clk), .reset(reset), .rd_en(RdEn), .addr(Ab),
        .wr_en0(WrEn0), .aw0(Aw0), .dw0(Dw0),
        .wr_en1(WrEn1), .aw1(Aw1), .dw1(Dw1),
        .stored(stored_b), .data(Db)
    );

endmodule

// File: doc/register_file_param.md
Name: register_file_param

Overview:
- Parametrised successor to the single-cycle CPU register file: configurable data width and depth, two write ports, two registered read ports, optional write-to-read bypass, optional hardwired zero register, read-enable hold and full clear on reset.
- Sits between decode (addresses) and execute/writeback in the CPU datapath. Also serves a dual-issue pipeline, where both write lanes can retire in the same cycle.

Parameters:
- WIDTH, 32, data width of each register in bits.
- DEPTH, 32, number of registers.
- ADDR_W, 5, address width; must satisfy 2**ADDR_W >= DEPTH.
- ZERO_REG, 1, when 1 register 0 always reads 0 and ignores writes.
- BYPASS, 1, when 1 a same-cycle write to the read address is forwarded to the read output.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- WrEn0  in  1  write enable, lane 0.
- Aw0  in  ADDR_W  write address, lane 0.
- Dw0  in  WIDTH  write data, lane 0.
- WrEn1  in  1  write enable, lane 1 (younger instruction).
- Aw1  in  ADDR_W  write address, lane 1.
- Dw1  in  WIDTH  write data, lane 1.
- RdEn  in  1  read enable; when 0, Da and Db hold their value.
- Aa  in  ADDR_W  read address, port A.
- Ab  in  ADDR_W  read address, port B.
- Da  out  WIDTH  registered read data, port A.
- Db  out  WIDTH  registered read data, port B.

Behaviour:
- Reset: while reset=1, asynchronously force all DEPTH registers, Da and Db to 0. Reset asserted mid-operation discards any pending write in that cycle. First write is accepted on the first rising edge after reset deasserts.
- Write: on posedge clk, if WrEnN=1 and AwN<DEPTH, the register at AwN takes DwN.
  - Both lanes write the same address in the same cycle: lane 1 wins.
  - Address >= DEPTH: write is ignored.
  - ZERO_REG=1 and address 0: write is ignored.
- Read: on posedge clk, if RdEn=1, Da takes the read value for Aa and Db the read value for Ab. Latency is one cycle: the address is presented in cycle n and the data is visible after edge n.
  - RdEn=0: Da and Db hold their previous value. Writes still occur.
- Read value for address X, in priority order:
  1. ZERO_REG=1 and X=0: 0.
  2. X >= DEPTH: 0.
  3. BYPASS=1 and WrEn1=1 with Aw1=X (and the write is legal): Dw1.
  4. BYPASS=1 and WrEn0=1 with Aw0=X (and the write is legal): Dw0.
  5. Otherwise: the stored register contents before this edge.
- BYPASS=0: a read and a write to the same address in the same cycle returns the old value. The new value appears on the next read.
- Da and Db are fully independent. Aa=Ab is legal and both outputs return the same value.
- No X propagation: every register is defined from reset onward.
- The register array must be declared with DEPTH entries. Index width equals ADDR_W and must never be truncated.

Decomposition:
- Shared package register_file_pkg:
  - default constants RF_WIDTH=32, RF_DEPTH=32, RF_ADDR_W=5;
  - localparam RF_ZERO_ADDR=0;
  - a function that checks address legality (address < DEPTH, not zero when ZERO_REG).
- One sub-module: register_file_read_port.
  - Does the bypass/zero/out-of-range selection plus the RdEn-gated output register.
  - Instantiated twice, for A and B.
  - The write array and write arbitration stay in the top module.

Test Plan:
- Reset and zero register: assert reset mid-cycle with Da=0x1234 -> Da and Db read 0 immediately. After release, reading Aa=7, Ab=31 -> 0 on both.
- Basic latency: write Aw0=3, Dw0=0xDEADBEEF. Next cycle Aa=3 with RdEn=1 -> Da=0xDEADBEEF one edge later. Db for Ab=4 -> 0.
- Dual write conflict: WrEn0=WrEn1=1, Aw0=Aw1=5, Dw0=0x11, Dw1=0x22 -> later read of 5 returns 0x22. Different addresses (5 and 6) -> both values are stored.
- Bypass: BYPASS=1, write Aw1=9, Dw1=0xA5A5 while Aa=9 -> Da=0xA5A5 after the same edge. With BYPASS=0, same stimulus -> old value (0), then 0xA5A5 on the next read.
- Zero register and range: write Aw0=0, Dw0=0xFFFF -> read of 0 returns 0. With DEPTH=24, write to 30 is ignored and a read of 30 returns 0.
- Hold: load Da=0x55, set RdEn=0, change Aa and write a new value to the old address -> Da stays 0x55 until RdEn=1. Then Da updates on the following edge.
